// File: rtl/rob_tag_ctrl.sv
// -----------------------------------------------------------------------------
// rob_tag_ctrl
//
// Reorder-buffer tag controller between decode/dispatch and writeback.
// It hands out in-order tags 1..DEPTH to decode, marks them complete on
// writeback, and retires completed tags strictly in program order, at most
// one per cycle. Tag 0 means "no tag" and is never allocated.
//
// Optional feature macro: ROB_WB_BYPASS_EN
//   When defined, a writeback that hits the current head counts as done for
//   that same edge's commit decision, so the commit pulse comes one cycle
//   earlier. When undefined, commit looks only at the registered done bit.
//
// Parameters
//   TAG_W  tag width in bits
//   DEPTH  number of entries (tags 1..DEPTH), DEPTH <= 2^TAG_W - 1
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   alloc_en      decode dispatches an instruction this cycle
//   target        tag the next dispatch receives; 0 when full or in reset
//   rob_full      no free entry
//   wb_valid      writeback result valid this cycle
//   wb_tag        tag of the completing instruction
//   flush         squash every in-flight entry (highest priority)
//   commit_valid  registered one-cycle pulse per retired tag
//   commit_tag    retired tag while commit_valid=1, else 0
//   count         number of occupied entries
// -----------------------------------------------------------------------------
module rob_tag_ctrl #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    output logic [TAG_W-1:0] target,
    output logic             rob_full,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   ONE_CNT   = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(DEPTH);
    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [DEPTH:1]   busy;
    logic [DEPTH:1]   done;
    logic [DEPTH:1]   wb_hit;
    logic             head_done;
    logic             not_full;
    logic             do_alloc;
    logic             do_commit;
`ifdef ROB_WB_BYPASS_EN
    logic             head_wb;
`endif

    // Pointers live in 1..DEPTH; the wrap skips the reserved tag 0.
    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
        return (p == LAST_TAG) ? FIRST_TAG : p + FIRST_TAG;
    endfunction

    // Per-entry decode: loops over 1..DEPTH so tag 0 and out-of-range tags
    // can never match an entry.
    always_comb begin
        wb_hit    = '0;
        head_done = 1'b0;
`ifdef ROB_WB_BYPASS_EN
        head_wb   = 1'b0;
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            // An entry being allocated this edge is not busy yet, so a
            // writeback to it is dropped here automatically.
            wb_hit[i] = wb_valid && (wb_tag == TAG_W'(i)) && busy[i];
            if (head == TAG_W'(i)) begin
                head_done = done[i];
`ifdef ROB_WB_BYPASS_EN
                head_wb   = wb_valid && (wb_tag == TAG_W'(i)) && busy[i];
`endif
            end
        end
    end

    always_comb begin
        not_full = (count != DEPTH_CNT);
        do_alloc = alloc_en && not_full;
`ifdef ROB_WB_BYPASS_EN
        do_commit = (count != '0) && (head_done || head_wb);
`else
        do_commit = (count != '0) && head_done;
`endif
        // Gate with rst so outputs read their reset values while rst is low.
        target   = (rst && not_full) ? tail : '0;
        rob_full = rst && !not_full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= FIRST_TAG;
            tail         <= FIRST_TAG;
            count        <= '0;
            busy         <= '0;
            done         <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
        end else if (flush) begin
            head         <= FIRST_TAG;
            tail         <= FIRST_TAG;
            count        <= '0;
            busy         <= '0;
            done         <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
        end else begin
            if (do_alloc) begin
                tail <= next_ptr(tail);
            end
            if (do_commit) begin
                head <= next_ptr(head);
            end
            commit_valid <= do_commit;
            commit_tag   <= do_commit ? head : '0;

            case ({do_alloc, do_commit})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase

            // Alloc and commit never target the same entry: head==tail with
            // entries in flight only when full, and then alloc is blocked.
            for (int i = 1; i <= DEPTH; i++) begin
                if (do_alloc && (tail == TAG_W'(i))) begin
                    busy[i] <= 1'b1;
                    done[i] <= 1'b0;
                end else if (do_commit && (head == TAG_W'(i))) begin
                    busy[i] <= 1'b0;
                    done[i] <= 1'b0;
                end else if (wb_hit[i]) begin
                    done[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_tag_ctrl
//
// Scoreboard bench for rob_tag_ctrl. The driver applies one cycle of
// stimulus per falling edge and advances a queue-based program-order model
// of the reorder buffer, pushing the expected post-edge outputs. A separate
// monitor pops one expectation after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_rob_tag_ctrl;

    localparam int TAG_W = 4;
    localparam int DEPTH = 15;

    logic             clk;
    logic             rst;
    logic             alloc_en;
    logic [TAG_W-1:0] target;
    logic             rob_full;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             flush;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic [TAG_W:0]   count;

    rob_tag_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_en     (alloc_en),
        .target       (target),
        .rob_full     (rob_full),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cv;
        int tag;
        int cnt;
        int tgt;
        int full;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    // Reference model: in-flight tags in program order plus a done flag per tag.
    int   inflight[$];
    bit   done_m[0:15];
    int   next_tag = 1;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit in_flight(input int t);
        foreach (inflight[k]) if (inflight[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit a, input bit wv, input int wt, input bit fl);
        exp_t e;
        int   sz;
        bit   cm;
        bit   hit;
        int   ctag;
        sz   = inflight.size();
        cm   = 1'b0;
        ctag = 0;
        if (fl) begin
            inflight.delete();
            for (int k = 0; k < 16; k++) done_m[k] = 1'b0;
            next_tag = 1;
        end else begin
            hit = wv && in_flight(wt);
            if (sz > 0) cm = done_m[inflight[0]];
`ifdef ROB_WB_BYPASS_EN
            if (sz > 0 && wv && wt == inflight[0]) cm = 1'b1;
`endif
            if (hit) done_m[wt] = 1'b1;
            if (cm) begin
                ctag = inflight.pop_front();
                done_m[ctag] = 1'b0;
            end
            if (a && sz < DEPTH) begin
                inflight.push_back(next_tag);
                done_m[next_tag] = 1'b0;
                next_tag = next_tag % DEPTH + 1;
            end
        end
        e.cv   = cm ? 1 : 0;
        e.tag  = ctag;
        e.cnt  = inflight.size();
        e.full = (inflight.size() == DEPTH) ? 1 : 0;
        e.tgt  = e.full ? 0 : next_tag;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit a, input bit wv, input int wt, input bit fl);
        @(negedge clk);
        alloc_en = a;
        wb_valid = wv;
        wb_tag   = wt[TAG_W-1:0];
        flush    = fl;
        model_step(a, wv, wt, fl);
        mon_en = 1'b1;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_valid", int'(commit_valid), e.cv);
                chk("commit_tag",   int'(commit_tag),   e.tag);
                chk("count",        int'(count),        e.cnt);
                chk("target",       int'(target),       e.tgt);
                chk("rob_full",     int'(rob_full),     e.full);
            end
        end
    end

    initial begin
        int wt;
        rst      = 1'b0;
        alloc_en = 1'b0;
        wb_valid = 1'b0;
        wb_tag   = '0;
        flush    = 1'b0;
        for (int k = 0; k < 16; k++) done_m[k] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_target",       int'(target),       0);
        chk("reset_rob_full",     int'(rob_full),     0);
        chk("reset_count",        int'(count),        0);
        chk("reset_commit_valid", int'(commit_valid), 0);
        chk("reset_commit_tag",   int'(commit_tag),   0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_reset_target", int'(target), 1);

        // Fill to full, then one extra alloc that must be ignored.
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Out-of-order writebacks, in-order retire.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(0, 1, 3, 0);
        cycle(0, 1, 2, 0);
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);

        // Wrap-around: fill, retire everything, reissue 1 and 2.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0);
        for (int i = 1; i <= 15; i++) cycle(0, 1, i, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 2, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Full with concurrent alloc and commit.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Flush with writeback on the same edge; later writeback ignored.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        cycle(0, 1, 4, 0);
        cycle(0, 1, 5, 0);
        cycle(0, 1, 3, 1);
        cycle(0, 1, 3, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Single-entry writeback latency; writeback to a tag being allocated.
        cycle(0, 0, 0, 1);
        cycle(1, 1, 1, 0);
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 15, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1)
                wt = inflight[$urandom_range(0, inflight.size() - 1)];
            else
                wt = $urandom_range(0, 15);
            cycle($urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 6,
                  wt,
                  $urandom_range(0, 49) == 0);
        end

        // Leave entries in flight, then assert reset between edges.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
        alloc_en = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_target",       int'(target),       0);
        chk("async_reset_rob_full",     int'(rob_full),     0);
        chk("async_reset_count",        int'(count),        0);
        chk("async_reset_commit_valid", int'(commit_valid), 0);
        chk("async_reset_commit_tag",   int'(commit_tag),   0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
